count_serializer: RTL and testbench
===================================

COUNT_SERIALIZER -- requirements
Module: count_serializer

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame; legal range 1..16.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..65535.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Port in_data, input, WIDTH: parallel word to send, normally the upstream counter's out value.
REQ-006 Port in_valid, input, 1: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1: block can accept a word this cycle.
REQ-008 Port tx, output, 1: serial line, idle high, registered.
REQ-009 Port busy, output, 1: a frame is in progress; always equals NOT in_ready.

Function
REQ-010 The block SHALL have four states: IDLE, START, DATA, STOP.
REQ-011 in_ready SHALL be 1 only in IDLE and SHALL be decoded from the state register, with no combinational path from in_valid.
REQ-012 A word SHALL be accepted at a rising edge where in_valid=1 and in_ready=1. in_data SHALL be latched into a WIDTH-bit shift register at that edge. The state SHALL become START.
REQ-013 In IDLE with in_valid=0, the block SHALL remain in IDLE with tx=1.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles. The first of these cycles is the cycle immediately after the accepting edge.
REQ-015 DATA: the latched bits SHALL be driven on tx LSB first. Each bit is held for CLKS_PER_BIT cycles. The state lasts WIDTH*CLKS_PER_BIT cycles.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles. The state then returns to IDLE.
REQ-017 Total frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles, measured from the accepting edge to the edge that re-enters IDLE.
REQ-018 A bit-period counter SHALL count 0..CLKS_PER_BIT-1. It SHALL wrap to 0 at each bit boundary. It SHALL be held at 0 in IDLE.
REQ-019 A bit index counter SHALL count 0..WIDTH-1 in DATA. The last data bit SHALL be followed directly by STOP, with no extra cycle.
REQ-020 With CLKS_PER_BIT=1, each state and each data bit SHALL last exactly one cycle.
REQ-021 Back-to-back frames: at least one IDLE cycle (tx=1, in_ready=1) SHALL separate consecutive frames.
REQ-022 The minimum spacing between acceptances SHALL be (WIDTH+2)*CLKS_PER_BIT+1 cycles.
REQ-023 in_valid and in_data SHALL be ignored outside IDLE. A word presented while busy is not consumed.
REQ-024 A change of in_data after acceptance SHALL NOT affect the frame in progress.
REQ-025 Counters SHALL be sized to hold CLKS_PER_BIT-1 and WIDTH-1 without overflow for all legal parameter values.

Reset
REQ-026 While reset=1 at a rising edge, the state SHALL become IDLE, tx SHALL be 1, and all counters and the shift register SHALL be 0.
REQ-027 After reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame at that edge. tx SHALL be 1 from the following cycle. The partial word SHALL be discarded and never resumed.
REQ-029 in_valid SHALL NOT cause acceptance at any edge where reset=1.

Verification (WIDTH=4, CLKS_PER_BIT=4 unless stated)
REQ-030 Reset then idle:
- Stimulus: reset high for 2 cycles, then low, with in_valid=0 for 10 cycles.
- Required: tx=1, in_ready=1, busy=0 throughout.
REQ-031 Single frame:
- Stimulus: in_data=4'b1010 with in_valid pulsed for 1 cycle.
- Required tx per 4-cycle slot: 0 (start), 0, 1, 0, 1, 1 (stop).
- Required: in_ready=0 for exactly 24 cycles, then 1.
REQ-032 Busy rejection:
- Stimulus: in_valid held high continuously with in_data cycling 0..15 each cycle.
- Required: accepted words are only those sampled on in_ready=1 edges.
- Required: frames start 25 cycles apart, each carrying the value latched at its acceptance edge.
REQ-033 Reset mid-frame:
- Stimulus: assert reset for 1 cycle, 10 cycles after accepting 4'hF.
- Required: tx=1 the next cycle and in_ready=1.
- Required: a new word 4'h3 is then sent intact as 0, 1, 1, 0, 0, 1.
REQ-034 Fast rate, with CLKS_PER_BIT=1:
- Stimulus: send 4'h0, then 4'hF, each with in_valid held until accepted.
- Required tx: 0, 0, 0, 0, 0, 1, then 1 idle cycle, then 0, 1, 1, 1, 1, 1.
- Required: 6-cycle frames separated by exactly 1 idle cycle.

Source files
------------

// File: rtl/count_serializer.sv
// Frame serializer: accepts a WIDTH-bit word when idle and sends it as
// start bit (0), data LSB first, stop bit (1), each held CLKS_PER_BIT cycles.
module count_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic               tx_q, tx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;

  logic               accept;
  logic               bit_end;
  logic [WIDTH-1:0]   shreg_shift;

  // Ready is decoded from the state register only, so in_valid never
  // reaches in_ready combinationally.
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = ~in_ready;
  assign tx          = tx_q;
  assign accept      = in_valid & in_ready;
  assign bit_end     = (cnt_q == CNT_LAST);
  assign shreg_shift = shreg_q >> 1;

  // tx_d is computed from the state being entered, so the registered tx
  // changes on the same edge as the state.
  always_comb begin
    // NOTE: every signal gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_d = state_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (accept) begin
          state_d = S_START;
          shreg_d = in_data;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_shift;
            tx_d    = shreg_shift[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the shift register is cleared on reset so an aborted word
      // cannot linger in the datapath.
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_count_serializer.sv
// Scoreboard bench for count_serializer: a slow lane (CLKS_PER_BIT=4) and a
// fast lane (CLKS_PER_BIT=1), each with an expected-frame queue and a monitor.
module tb_count_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_s, rst_f;
  logic [3:0] data_s, data_f;
  logic       valid_s, valid_f;
  logic       ready_s, ready_f;
  logic       tx_s, tx_f;
  logic       busy_s, busy_f;

  count_serializer #(.WIDTH(4), .CLKS_PER_BIT(4)) dut_slow (
    .clock(clock), .reset(rst_s), .in_data(data_s), .in_valid(valid_s),
    .in_ready(ready_s), .tx(tx_s), .busy(busy_s)
  );

  count_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_fast (
    .clock(clock), .reset(rst_f), .in_data(data_f), .in_valid(valid_f),
    .in_ready(ready_f), .tx(tx_f), .busy(busy_f)
  );

  // len: busy cycles expected for the frame; gap: cycles since previous
  // frame start (0 = not checked).
  typedef struct packed {
    logic [3:0] data;
    logic [7:0] len;
    logic [7:0] gap;
  } exp_t;

  exp_t q_s[$];
  exp_t q_f[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  bit mon_on     = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame waveform: start 0, data LSB first, stop 1, each cpb samples long.
  function automatic logic [23:0] exp_wave(input logic [3:0] d, input int cpb);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 6 * cpb; i++) begin
      int slot;
      slot = i / cpb;
      if (slot == 0)      w[i] = 1'b0;
      else if (slot == 5) w[i] = 1'b1;
      else                w[i] = d[slot-1];
    end
    return w;
  endfunction

  task automatic frame_end(input string lane, input bit have, input exp_t e, input int cnt,
                           input logic [23:0] rec, input int cpb, input int gap,
                           input logic tx_now);
    logic [23:0] mask;
    check({lane, "_exp_pending"}, 32'(have), 32'd1);
    if (!have) return;
    mask = (24'(1) << e.len) - 24'(1);
    check({lane, "_tx_after_frame"}, 32'(tx_now), 32'd1);
    check({lane, "_busy_len"}, 32'(cnt), 32'(e.len));
    check({lane, "_wave"}, 32'(rec & mask), 32'(exp_wave(e.data, cpb) & mask));
    if (e.gap != 0) check({lane, "_start_gap"}, 32'(gap), 32'(e.gap));
  endtask

  // Slow-lane monitor
  bit          in_s = 1'b0;
  int          cnt_s, gap_s, last_s = 0;
  logic [23:0] rec_s;
  exp_t        e_s;
  bit          have_s;
  always @(negedge clock) if (mon_on) begin
    check("slow_busy_vs_ready", 32'(busy_s), 32'(!ready_s));
    if (in_s && !busy_s) begin
      have_s = (q_s.size() > 0);
      e_s    = have_s ? q_s.pop_front() : '0;
      frame_end("slow", have_s, e_s, cnt_s, rec_s, 4, gap_s, tx_s);
      in_s = 1'b0;
    end else if (in_s) begin
      if (cnt_s < 24) rec_s[cnt_s] = tx_s;
      cnt_s++;
    end else if (busy_s) begin
      in_s  = 1'b1;
      cnt_s = 1;
      rec_s = '0;
      rec_s[0] = tx_s;
      gap_s  = cyc - last_s;
      last_s = cyc;
    end else begin
      check("slow_idle_tx", 32'(tx_s), 32'd1);
    end
  end

  // Fast-lane monitor
  bit          in_f = 1'b0;
  int          cnt_f, gap_f, last_f = 0;
  logic [23:0] rec_f;
  exp_t        e_f;
  bit          have_f;
  always @(negedge clock) if (mon_on) begin
    check("fast_busy_vs_ready", 32'(busy_f), 32'(!ready_f));
    if (in_f && !busy_f) begin
      have_f = (q_f.size() > 0);
      e_f    = have_f ? q_f.pop_front() : '0;
      frame_end("fast", have_f, e_f, cnt_f, rec_f, 1, gap_f, tx_f);
      in_f = 1'b0;
    end else if (in_f) begin
      if (cnt_f < 24) rec_f[cnt_f] = tx_f;
      cnt_f++;
    end else if (busy_f) begin
      in_f  = 1'b1;
      cnt_f = 1;
      rec_f = '0;
      rec_f[0] = tx_f;
      gap_f  = cyc - last_f;
      last_f = cyc;
    end else begin
      check("fast_idle_tx", 32'(tx_f), 32'd1);
    end
  end

  task automatic send_s(input logic [3:0] d);
    int n;
    n = 0;
    data_s  = d;
    valid_s = 1'b1;
    while (!ready_s && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!ready_s) check("slow_accept_timeout", 32'(ready_s), 32'd1);
    @(posedge clock); #1;
    valid_s = 1'b0;
  endtask

  task automatic send_f(input logic [3:0] d);
    int n;
    n = 0;
    data_f  = d;
    valid_f = 1'b1;
    while (!ready_f && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!ready_f) check("fast_accept_timeout", 32'(ready_f), 32'd1);
    @(posedge clock); #1;
    valid_f = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = 1'b1; rst_f = 1'b1;
    valid_s = 1'b0; valid_f = 1'b0;
    data_s = '0; data_f = '0;

    // Reset for two cycles, then ten idle cycles.
    repeat (2) @(posedge clock);
    #1;
    rst_s = 1'b0; rst_f = 1'b0;
    mon_on = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("slow_idle_after_reset", 32'({tx_s, ready_s, busy_s}), 32'b110);
      check("fast_idle_after_reset", 32'({tx_f, ready_f, busy_f}), 32'b110);
    end

    // Single frame 4'b1010: 0,0,1,0,1,1 per 4-cycle slot, 24 busy cycles.
    q_s.push_back('{data: 4'hA, len: 8'd24, gap: 8'd0});
    send_s(4'hA);
    repeat (30) @(posedge clock);
    #1;

    // in_valid held with in_data = edge index mod 16: accepts 0, 9, 2, 25 apart.
    q_s.push_back('{data: 4'h0, len: 8'd24, gap: 8'd0});
    q_s.push_back('{data: 4'h9, len: 8'd24, gap: 8'd25});
    q_s.push_back('{data: 4'h2, len: 8'd24, gap: 8'd25});
    valid_s = 1'b1;
    for (int k = 0; k < 51; k++) begin
      data_s = 4'(k);
      @(posedge clock); #1;
    end
    valid_s = 1'b0;
    repeat (30) @(posedge clock);
    #1;

    // Reset on the 10th edge after accepting 4'hF: frame cut after 10 busy cycles.
    q_s.push_back('{data: 4'hF, len: 8'd10, gap: 8'd0});
    send_s(4'hF);
    data_s = 4'h0;
    repeat (9) @(posedge clock);
    #1;
    rst_s = 1'b1;
    @(posedge clock); #1;
    rst_s = 1'b0;
    check("slow_abort_tx", 32'(tx_s), 32'd1);
    check("slow_abort_ready", 32'(ready_s), 32'd1);
    q_s.push_back('{data: 4'h3, len: 8'd24, gap: 8'd0});
    send_s(4'h3);
    repeat (30) @(posedge clock);
    #1;

    // Fast lane: 4'h0 then 4'hF, 6-cycle frames, next start 7 cycles later.
    q_f.push_back('{data: 4'h0, len: 8'd6, gap: 8'd0});
    q_f.push_back('{data: 4'hF, len: 8'd6, gap: 8'd7});
    send_f(4'h0);
    send_f(4'hF);
    repeat (12) @(posedge clock);
    #1;

    // in_valid during reset must not start a frame.
    rst_f = 1'b1; valid_f = 1'b1; data_f = 4'h5;
    repeat (2) @(posedge clock);
    #1;
    check("fast_ready_in_reset", 32'(ready_f), 32'd1);
    rst_f = 1'b0; valid_f = 1'b0;
    repeat (10) @(posedge clock);
    #1;

    check("slow_queue_drained", 32'(q_s.size()), 32'd0);
    check("fast_queue_drained", 32'(q_f.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
